// File: rtl/brc_resolve_pkg.sv
// Shared types for the branch resolution unit: request/response records, opcode enums, widths.
// Widths are package constants so the records stay packed and can cross the interface unchanged.
package brc_resolve_pkg;

    localparam int XLEN  = 32;
    localparam int TAG_W = 6;
    localparam int CH_W  = 4;

    typedef logic        [XLEN-1:0] xlen_t;
    typedef logic signed [XLEN-1:0] slen_t;

    localparam xlen_t BRC_LINK_OFS = xlen_t'(4);

    typedef enum logic [1:0] {
        BRC_BRANCH = 2'd0,
        BRC_JUMP   = 2'd1,
        BRC_JALR   = 2'd2
    } brc_ty_t;

    // Codes 2 and 3 are deliberately unassigned and resolve as not-taken.
    typedef enum logic [2:0] {
        BRC_BEQ  = 3'd0,
        BRC_BNE  = 3'd1,
        BRC_BLT  = 3'd4,
        BRC_BGE  = 3'd5,
        BRC_BLTU = 3'd6,
        BRC_BGEU = 3'd7
    } brc_branch_t;

    typedef struct packed {
        brc_ty_t     ty;
        brc_branch_t br;
    } brc_fun_t;

    typedef struct packed {
        xlen_t [1:0]      ops;
        brc_fun_t         fun;
        xlen_t            pc;
        xlen_t            imm;
        logic             pred_taken;
        xlen_t            pred_target;
        logic [TAG_W-1:0] tag;
    } brc_req_t;

    // target carries the resolved next-PC: branch target when taken, pc+4 otherwise.
    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [CH_W-1:0]  ch;
        logic             taken;
        xlen_t            target;
        xlen_t            link;
        logic             mispredict;
        logic             misalign;
    } brc_resp_t;

endpackage

// File: rtl/brc_resolve_if.sv
// Issue-side and result-side handshake bundle of the branch resolution unit.
// master = issuing/consuming logic, slave = the resolution unit.
interface brc_resolve_if #(
    parameter int NUM_CH = 2
);
    import brc_resolve_pkg::*;

    logic     [NUM_CH-1:0] in_valid;
    logic     [NUM_CH-1:0] in_ready;
    brc_req_t [NUM_CH-1:0] in_req;
    logic                  out_valid;
    logic                  out_ready;
    brc_resp_t             out_resp;

    modport master (
        output in_valid,
        output in_req,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_resp
    );

    modport slave (
        input  in_valid,
        input  in_req,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_resp
    );

endinterface

// File: rtl/brc_resolve_rr_arb.sv
// Round-robin arbiter: grants the first requester at or after the pointer, combinational grant.
// Pointer moves to grant+1 only when the grant is consumed (adv_i); otherwise it holds.
module brc_rr_arb #(
    parameter int NUM_CH = 2,
    parameter int PTR_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NUM_CH-1:0] req_i,
    input  logic              adv_i,
    output logic [NUM_CH-1:0] grant_o,
    output logic [PTR_W-1:0]  grant_idx_o,
    output logic              any_o
);

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;

    always_comb begin
        int idx;
        idx         = 0;
        grant_o     = '0;
        grant_idx_o = '0;
        any_o       = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NUM_CH) begin
                idx = idx - NUM_CH;
            end
            if (!any_o && req_i[idx]) begin
                any_o       = 1'b1;
                grant_idx_o = PTR_W'(idx);
            end
        end
        if (any_o) begin
            grant_o[grant_idx_o] = 1'b1;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (adv_i) begin
            if (grant_idx_o == PTR_W'(NUM_CH - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = grant_idx_o + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/brc_resolve.sv
// Branch resolution unit: RR-arbitrated issue, S1 evaluates condition/target, S2 holds the result.
// Accept to out_valid is 2 cycles; 1/cycle sustained; stalls hold S2 then S1. Optional BRC_STATS_EN.
module brc_resolve #(
    parameter int NUM_CH = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        flush,
    brc_resolve_if.slave bus
`ifdef BRC_STATS_EN
    ,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispred
`endif
);
    import brc_resolve_pkg::*;

    localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0] grant;
    logic [PTR_W-1:0]  grant_idx;
    logic              grant_any;

    logic      s1_vld_q, s1_vld_d;
    logic      s2_vld_q, s2_vld_d;
    brc_resp_t s1_q, s1_d;
    brc_resp_t s2_q, s2_d;

    logic s2_load;
    logic s1_can_load;
    logic accept;
    logic fire;

    brc_req_t  win;
    brc_resp_t resp_new;
    xlen_t     br_sum;
    xlen_t     jr_sum;
    xlen_t     link;
    xlen_t     tgt;
    logic      op_eq;
    logic      op_lt;
    logic      op_ltu;
    logic      cond_taken;
    logic      misalign;

    assign fire        = s2_vld_q & bus.out_ready;
    assign s2_load     = ~s2_vld_q | bus.out_ready;
    assign s1_can_load = ~s1_vld_q | s2_load;
    assign accept      = grant_any & s1_can_load & ~flush & ~reset;

    assign bus.in_ready  = grant & {NUM_CH{accept}};
    assign bus.out_valid = s2_vld_q;
    assign bus.out_resp  = s2_q;

    brc_rr_arb #(
        .NUM_CH (NUM_CH),
        .PTR_W  (PTR_W)
    ) u_arb (
        .clock       (clock),
        .reset       (reset),
        .req_i       (bus.in_valid),
        .adv_i       (accept),
        .grant_o     (grant),
        .grant_idx_o (grant_idx),
        .any_o       (grant_any)
    );

    always_comb begin
        win        = bus.in_req[grant_idx];
        br_sum     = win.pc + win.imm;
        jr_sum     = win.ops[0] + win.imm;
        link       = win.pc + BRC_LINK_OFS;
        op_eq      = (win.ops[0] == win.ops[1]);
        op_lt      = (slen_t'(win.ops[0]) < slen_t'(win.ops[1]));
        op_ltu     = (win.ops[0] < win.ops[1]);
        cond_taken = 1'b0;
        tgt        = br_sum;

        case (win.fun.ty)
            BRC_BRANCH: begin
                case (win.fun.br)
                    BRC_BEQ:  cond_taken = op_eq;
                    BRC_BNE:  cond_taken = ~op_eq;
                    BRC_BLT:  cond_taken = op_lt;
                    BRC_BGE:  cond_taken = ~op_lt;
                    BRC_BLTU: cond_taken = op_ltu;
                    BRC_BGEU: cond_taken = ~op_ltu;
                    default:  cond_taken = 1'b0;
                endcase
            end
            BRC_JUMP: cond_taken = 1'b1;
            BRC_JALR: begin
                cond_taken = 1'b1;
                tgt        = {jr_sum[XLEN-1:1], 1'b0};
            end
            default: cond_taken = 1'b0;
        endcase

        // A misaligned target traps upstream, so it must not also trigger a redirect.
        misalign = cond_taken & tgt[1];

        resp_new            = '0;
        resp_new.tag        = win.tag;
        resp_new.ch         = CH_W'(grant_idx);
        resp_new.taken      = cond_taken;
        resp_new.target     = cond_taken ? tgt : link;
        resp_new.link       = link;
        resp_new.misalign   = misalign;
        resp_new.mispredict = ~misalign &
                              ((cond_taken != win.pred_taken) |
                               (cond_taken & (tgt != win.pred_target)));
    end

    always_comb begin
        s1_vld_d = s1_vld_q;
        s1_d     = s1_q;
        s2_vld_d = s2_vld_q;
        s2_d     = s2_q;
        if (flush) begin
            s1_vld_d = 1'b0;
            s2_vld_d = 1'b0;
        end else begin
            if (s2_load) begin
                s2_vld_d = s1_vld_q;
                if (s1_vld_q) begin
                    s2_d = s1_q;
                end
            end
            if (s1_can_load) begin
                s1_vld_d = accept;
                if (accept) begin
                    s1_d = resp_new;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_vld_q <= 1'b0;
            s2_vld_q <= 1'b0;
            s1_q     <= '0;
            s2_q     <= '0;
        end else begin
            s1_vld_q <= s1_vld_d;
            s2_vld_q <= s2_vld_d;
            s1_q     <= s1_d;
            s2_q     <= s2_d;
        end
    end

`ifdef BRC_STATS_EN
    logic [31:0] stat_br_q, stat_br_d;
    logic [31:0] stat_mp_q, stat_mp_d;

    // Saturating counters; flush does not clear them since fires in the flush cycle still count.
    always_comb begin
        stat_br_d = stat_br_q;
        stat_mp_d = stat_mp_q;
        if (fire && (stat_br_q != '1)) begin
            stat_br_d = stat_br_q + 32'd1;
        end
        if (fire && s2_q.mispredict && (stat_mp_q != '1)) begin
            stat_mp_d = stat_mp_q + 32'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stat_br_q <= '0;
            stat_mp_q <= '0;
        end else begin
            stat_br_q <= stat_br_d;
            stat_mp_q <= stat_mp_d;
        end
    end

    assign stat_branches = stat_br_q;
    assign stat_mispred  = stat_mp_q;
`endif

endmodule

// File: tb/tb_brc_resolve.sv
// Bench for brc_resolve: directed vector table, hand-written stall/flush/reset sequences and
// randomized traffic checked against an in-order transaction model of the unit.
module tb_brc_resolve;
    import brc_resolve_pkg::*;

    localparam int NUM_CH = 2;

    logic clock = 1'b0;
    logic reset;
    logic flush;

    always #5 clock = ~clock;

    brc_resolve_if #(.NUM_CH(NUM_CH)) bus();

`ifdef BRC_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_mispred;
`endif

    brc_resolve #(.NUM_CH(NUM_CH)) dut (
        .clock (clock),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
`ifdef BRC_STATS_EN
        ,
        .stat_branches (stat_branches),
        .stat_mispred  (stat_mispred)
`endif
    );

    typedef struct {
        brc_resp_t resp;
        int        acc;
    } inflight_t;

    typedef struct {
        brc_ty_t     ty;
        brc_branch_t br;
        xlen_t       a;
        xlen_t       b;
        xlen_t       pc;
        xlen_t       imm;
        logic        pt;
        xlen_t       ptgt;
        logic        e_tk;
        xlen_t       e_tgt;
        logic        e_mis;
        logic        e_mal;
    } vec_t;

    inflight_t         q[$];
    int                ptr;
    int                cyc;
    int                checks;
    int                failures;
    int                exp_br;
    int                exp_mp;
    logic [NUM_CH-1:0] dut_rdy_seen;
    logic              dut_ov_seen;

    task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", nm, act, exp);
        end
    endtask

    // Reference resolution from the architectural rules, using 64-bit arithmetic.
    function automatic brc_resp_t ref_resolve(brc_req_t r, int ch);
        brc_resp_t         o;
        longint unsigned   ua, ub, t64;
        longint            sa, sb;
        bit                tk;
        logic [31:0]       tgt, link;
        ua = r.ops[0];
        ub = r.ops[1];
        sa = $signed(r.ops[0]);
        sb = $signed(r.ops[1]);
        tk = 1'b0;
        case (r.fun.ty)
            BRC_BRANCH: begin
                case (r.fun.br)
                    BRC_BEQ:  tk = (ua == ub);
                    BRC_BNE:  tk = (ua != ub);
                    BRC_BLT:  tk = (sa < sb);
                    BRC_BGE:  tk = (sa >= sb);
                    BRC_BLTU: tk = (ua < ub);
                    BRC_BGEU: tk = (ua >= ub);
                    default:  tk = 1'b0;
                endcase
            end
            BRC_JUMP, BRC_JALR: tk = 1'b1;
            default: tk = 1'b0;
        endcase
        if (r.fun.ty == BRC_JALR) begin
            t64 = ua + longint'(r.imm);
            tgt = t64[31:0] & 32'hFFFF_FFFE;
        end else begin
            t64 = longint'(r.pc) + longint'(r.imm);
            tgt = t64[31:0];
        end
        t64  = longint'(r.pc) + 64'd4;
        link = t64[31:0];
        o            = '0;
        o.tag        = r.tag;
        o.ch         = CH_W'(ch);
        o.taken      = tk;
        o.target     = tk ? tgt : link;
        o.link       = link;
        o.misalign   = tk && tgt[1];
        o.mispredict = !o.misalign && ((tk != r.pred_taken) || (tk && (tgt != r.pred_target)));
        return o;
    endfunction

    function automatic brc_req_t rand_req();
        brc_req_t  r;
        brc_resp_t t;
        r            = '0;
        r.fun.ty     = brc_ty_t'($urandom_range(0, 3));
        r.fun.br     = brc_branch_t'($urandom_range(0, 7));
        r.ops[0]     = $urandom;
        case ($urandom_range(0, 3))
            0:       r.ops[1] = r.ops[0];
            1:       r.ops[1] = xlen_t'($urandom_range(0, 8)) - 32'd4;
            2:       r.ops[0] = xlen_t'($urandom_range(0, 8)) - 32'd4;
            default: r.ops[1] = $urandom;
        endcase
        r.pc         = $urandom & 32'hFFFF_FFFC;
        r.imm        = ($urandom_range(0, 3) != 0) ? ($urandom & 32'hFFFF_FFFC) : $urandom;
        r.tag        = TAG_W'($urandom);
        r.pred_taken = 1'($urandom_range(0, 1));
        r.pred_target = $urandom;
        t = ref_resolve(r, 0);
        if ($urandom_range(0, 1) == 1) r.pred_taken = t.taken;
        if ($urandom_range(0, 1) == 1) r.pred_target = t.target;
        return r;
    endfunction

    // One clock cycle: drive, check outputs against the model, then advance the model.
    task automatic step(input logic [NUM_CH-1:0] v, input logic ordy, input logic fl, input logic rs);
        bit                exp_ov, can;
        int                g;
        logic [NUM_CH-1:0] exp_rdy;
        brc_req_t          rq;
        inflight_t         e;
        bus.in_valid  = v;
        bus.out_ready = ordy;
        flush         = fl;
        reset         = rs;
        #1;
        exp_ov = (q.size() > 0) && ((cyc - q[0].acc) >= 2);
        can    = (q.size() < 2) || (exp_ov && ordy);
        g      = -1;
        for (int k = 0; k < NUM_CH; k++) begin
            if (g < 0 && v[(ptr + k) % NUM_CH]) g = (ptr + k) % NUM_CH;
        end
        exp_rdy = '0;
        if (!rs && !fl && can && g >= 0) exp_rdy[g] = 1'b1;
        dut_rdy_seen = bus.in_ready;
        dut_ov_seen  = bus.out_valid;
        chk("out_valid", 192'(bus.out_valid), 192'(exp_ov));
        if (exp_ov) chk("out_resp", 192'(bus.out_resp), 192'(q[0].resp));
        chk("in_ready", 192'(bus.in_ready), 192'(exp_rdy));
`ifdef BRC_STATS_EN
        chk("stat_branches", 192'(stat_branches), 192'(exp_br));
        chk("stat_mispred", 192'(stat_mispred), 192'(exp_mp));
`endif
        rq = '0;
        if (g >= 0) rq = bus.in_req[g];
        @(posedge clock);
        if (rs) begin
            q.delete();
            ptr    = 0;
            exp_br = 0;
            exp_mp = 0;
        end else begin
            if (exp_ov && ordy) begin
                exp_br++;
                if (q[0].resp.mispredict) exp_mp++;
                void'(q.pop_front());
            end
            if (fl) begin
                q.delete();
            end else if (exp_rdy != '0) begin
                e.resp = ref_resolve(rq, g);
                e.acc  = cyc;
                q.push_back(e);
                ptr = (g + 1) % NUM_CH;
            end
        end
        cyc++;
        @(negedge clock);
    endtask

    task automatic drain();
        for (int k = 0; k < 4; k++) step('0, 1'b1, 1'b0, 1'b0);
    endtask

    vec_t vec[12];

    initial begin
        #500000;
        $display("FAIL watchdog expired got=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int        accepts, fires, p0;
        brc_req_t  r;

        checks = 0; failures = 0; ptr = 0; cyc = 0; exp_br = 0; exp_mp = 0;
        bus.in_valid = '0; bus.out_ready = 1'b0; bus.in_req = '0;
        flush = 1'b0; reset = 1'b1;

        vec[0]  = '{BRC_BRANCH, BRC_BEQ,  32'd5,        32'd5, 32'h100,      32'h20,       1'b0, 32'h0,        1'b1, 32'h120,  1'b1, 1'b0};
        vec[1]  = '{BRC_BRANCH, BRC_BLT,  32'hFFFFFFFF, 32'd1, 32'h200,      32'h40,       1'b1, 32'h240,      1'b1, 32'h240,  1'b0, 1'b0};
        vec[2]  = '{BRC_BRANCH, BRC_BLTU, 32'hFFFFFFFF, 32'd1, 32'h200,      32'h40,       1'b1, 32'h240,      1'b0, 32'h204,  1'b1, 1'b0};
        vec[3]  = '{BRC_JALR,   BRC_BEQ,  32'h203,      32'd0, 32'h300,      32'h0,        1'b1, 32'h202,      1'b1, 32'h202,  1'b0, 1'b1};
        vec[4]  = '{BRC_BRANCH, BRC_BNE,  32'd7,        32'd7, 32'h400,      32'h8,        1'b0, 32'h0,        1'b0, 32'h404,  1'b0, 1'b0};
        vec[5]  = '{BRC_BRANCH, BRC_BGE,  32'hFFFFFFFF, 32'd1, 32'h500,      32'h10,       1'b0, 32'h0,        1'b0, 32'h504,  1'b0, 1'b0};
        vec[6]  = '{BRC_BRANCH, BRC_BGEU, 32'hFFFFFFFF, 32'd1, 32'h500,      32'h10,       1'b1, 32'h600,      1'b1, 32'h510,  1'b1, 1'b0};
        vec[7]  = '{BRC_BRANCH, brc_branch_t'(3'd3), 32'd1, 32'd1, 32'h600,  32'h4,        1'b0, 32'h0,        1'b0, 32'h604,  1'b0, 1'b0};
        vec[8]  = '{BRC_JUMP,   BRC_BEQ,  32'd0,        32'd0, 32'hFFFFFFF0, 32'h20,       1'b1, 32'h10,       1'b1, 32'h10,   1'b0, 1'b0};
        vec[9]  = '{BRC_JUMP,   BRC_BEQ,  32'd0,        32'd0, 32'h700,      32'h6,        1'b1, 32'h706,      1'b1, 32'h706,  1'b0, 1'b1};
        vec[10] = '{BRC_JALR,   BRC_BEQ,  32'h1000,     32'd0, 32'h0,        32'hFFFFFFFC, 1'b0, 32'h0,        1'b1, 32'hFFC,  1'b1, 1'b0};
        vec[11] = '{BRC_BRANCH, BRC_BEQ,  32'd1,        32'd2, 32'h800,      32'h100,      1'b1, 32'h900,      1'b0, 32'h804,  1'b1, 1'b0};

        @(negedge clock);
        step('0, 1'b0, 1'b0, 1'b1);
        step('0, 1'b0, 1'b0, 1'b1);
        bus.in_valid = '1;
        #1;
        chk("rst_in_ready", 192'(bus.in_ready), 192'(0));
        chk("rst_out_valid", 192'(bus.out_valid), 192'(0));
        chk("rst_out_resp", 192'(bus.out_resp), 192'(0));

        // Directed vectors on channel 0, one at a time, checking the 2-cycle latency.
        for (int i = 0; i < 12; i++) begin
            r             = '0;
            r.fun.ty      = vec[i].ty;
            r.fun.br      = vec[i].br;
            r.ops[0]      = vec[i].a;
            r.ops[1]      = vec[i].b;
            r.pc          = vec[i].pc;
            r.imm         = vec[i].imm;
            r.pred_taken  = vec[i].pt;
            r.pred_target = vec[i].ptgt;
            r.tag         = TAG_W'(i + 1);
            bus.in_req[0] = r;
            step(2'b01, 1'b1, 1'b0, 1'b0);
            chk($sformatf("vec%0d_accept", i), 192'(dut_rdy_seen), 192'(2'b01));
            step('0, 1'b1, 1'b0, 1'b0);
            chk($sformatf("vec%0d_early", i), 192'(dut_ov_seen), 192'(0));
            #1;
            chk($sformatf("vec%0d_valid", i), 192'(bus.out_valid), 192'(1));
            chk($sformatf("vec%0d_taken", i), 192'(bus.out_resp.taken), 192'(vec[i].e_tk));
            chk($sformatf("vec%0d_target", i), 192'(bus.out_resp.target), 192'(vec[i].e_tgt));
            chk($sformatf("vec%0d_link", i), 192'(bus.out_resp.link), 192'(vec[i].pc + 32'd4));
            chk($sformatf("vec%0d_mispred", i), 192'(bus.out_resp.mispredict), 192'(vec[i].e_mis));
            chk($sformatf("vec%0d_misalign", i), 192'(bus.out_resp.misalign), 192'(vec[i].e_mal));
            chk($sformatf("vec%0d_tag", i), 192'(bus.out_resp.tag), 192'(i + 1));
            step('0, 1'b1, 1'b0, 1'b0);
        end

        // Both channels requesting with a free-flowing output: grants alternate.
        drain();
        p0 = ptr;
        for (int k = 0; k < 8; k++) begin
            bus.in_req[0] = rand_req();
            bus.in_req[1] = rand_req();
            step(2'b11, 1'b1, 1'b0, 1'b0);
            chk($sformatf("alt%0d_grant", k), 192'(dut_rdy_seen), 192'(1 << ((p0 + k) % 2)));
            if (k >= 2) chk($sformatf("alt%0d_out", k), 192'(dut_ov_seen), 192'(1));
        end

        // Output stalled for 5 cycles: only two requests fit, then both drain.
        drain();
        accepts = 0;
        for (int k = 0; k < 5; k++) begin
            bus.in_req[0] = rand_req();
            bus.in_req[1] = rand_req();
            step(2'b11, 1'b0, 1'b0, 1'b0);
            if (dut_rdy_seen != '0) accepts++;
        end
        chk("stall_accepts", 192'(accepts), 192'(2));
        fires = 0;
        for (int k = 0; k < 4; k++) begin
            step('0, 1'b1, 1'b0, 1'b0);
            if (dut_ov_seen) fires++;
        end
        chk("stall_drained", 192'(fires), 192'(2));

        // Flush with both stages full.
        drain();
        bus.in_req[0] = rand_req();
        bus.in_req[1] = rand_req();
        step(2'b11, 1'b0, 1'b0, 1'b0);
        step(2'b11, 1'b0, 1'b0, 1'b0);
        step(2'b11, 1'b0, 1'b1, 1'b0);
        chk("flush_in_ready", 192'(dut_rdy_seen), 192'(0));
        step('0, 1'b1, 1'b0, 1'b0);
        chk("flush_out_valid", 192'(dut_ov_seen), 192'(0));
        drain();

        // Reset with requests in flight drops them.
        bus.in_req[0] = rand_req();
        step(2'b01, 1'b0, 1'b0, 1'b0);
        step(2'b01, 1'b0, 1'b0, 1'b0);
        step('0, 1'b0, 1'b0, 1'b1);
        step('0, 1'b1, 1'b0, 1'b0);
        chk("midrst_out_valid", 192'(dut_ov_seen), 192'(0));
        drain();

`ifdef BRC_STATS_EN
        step('0, 1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 10; k++) begin
            r             = '0;
            r.fun.ty      = BRC_JUMP;
            r.pc          = 32'h1000;
            r.imm         = 32'h100;
            r.pred_taken  = (k >= 3);
            r.pred_target = 32'h1100;
            r.tag         = TAG_W'(k);
            bus.in_req[0] = r;
            step(2'b01, 1'b1, 1'b0, 1'b0);
        end
        drain();
        step('0, 1'b1, 1'b1, 1'b0);
        step('0, 1'b1, 1'b0, 1'b0);
        chk("stats_branches10", 192'(stat_branches), 192'(10));
        chk("stats_mispred3", 192'(stat_mispred), 192'(3));
        step('0, 1'b1, 1'b0, 1'b1);
        step('0, 1'b1, 1'b0, 1'b0);
        chk("stats_rst_branches", 192'(stat_branches), 192'(0));
        chk("stats_rst_mispred", 192'(stat_mispred), 192'(0));
`endif

        // Randomized traffic with stalls, occasional flushes and resets.
        for (int n = 0; n < 1500; n++) begin
            for (int c = 0; c < NUM_CH; c++) bus.in_req[c] = rand_req();
            step(NUM_CH'($urandom), ($urandom_range(0, 9) < 7), ($urandom_range(0, 31) == 0),
                 ($urandom_range(0, 199) == 0));
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
